// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
//
// Purpose : FSM state encoding, default arbitration limits and a counter
//           width helper shared by dmem_arbiter and arb_wait_counter.
// Ports   : none (package).
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_BURST = 2'd1,
        S_YIELD = 2'd2
    } arb_state_t;

    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_BURST_MAX = 8;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// rtl/dmem_arbiter_wait_counter.sv - saturating up-counter with clear
//
// Purpose : counts up to MAX_VAL and holds there; a clear restarts the count,
//           and clear together with increment loads 1 (first event of a new run).
// Ports   : clk, rst (sync, active-low), clr, inc -> count [W-1:0].
module arb_wait_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_VAL = DEF_MAX_WAIT,
    parameter int W       = cnt_width(DEF_MAX_WAIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LIMIT = W'(MAX_VAL);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != LIMIT)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of the single-port data memory
//
// Purpose : shares d_mem between the CPU M-stage port (priority) and a
//           DMA/debug loader port, with a starvation counter and bounded
//           locked bursts so both sides make forward progress.
// Ports   : clk, rst (sync, active-low)
//           cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//           dma_req/dma_we/dma_lock/dma_addr/dma_wdata -> dma_gnt,
//               dma_rdata, dma_rvalid (registered)
//           mem_we/mem_a/mem_wd -> d_mem, mem_rd <- d_mem (combinational)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(BURST_MAX);

    localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_LAST  = BURST_W'(BURST_MAX - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              dma_rvalid_q;
    logic              dma_rvalid_d;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [DATA_W-1:0] dma_rdata_d;

    logic               cpu_grant;
    logic               dma_grant;
    logic               burst_inc;
    logic               burst_clr;
    logic               wait_inc;
    logic               wait_clr;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;

    // Starvation counter: counts consecutive denied DMA cycles.
    assign wait_inc = dma_req && !dma_grant;
    assign wait_clr = dma_grant || !dma_req;

    arb_wait_counter #(
        .MAX_VAL (MAX_WAIT),
        .W       (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .count (wait_cnt)
    );

    // Burst beat counter: restarts outside S_BURST, so the opening grant in
    // S_CPU (clear + increment together) leaves it at 1.
    assign burst_clr = (state_q != S_BURST);

    arb_wait_counter #(
        .MAX_VAL (BURST_MAX),
        .W       (BURST_W)
    ) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (burst_clr),
        .inc   (burst_inc),
        .count (burst_cnt)
    );

    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        burst_inc = 1'b0;

        case (state_q)
            S_CPU: begin
                dma_grant = dma_req && (!cpu_req || (wait_cnt == WAIT_LIMIT));
                cpu_grant = cpu_req && !dma_grant;
                if (dma_grant && dma_lock) begin
                    burst_inc = 1'b1;
                    state_d   = S_BURST;
                end
            end
            S_BURST: begin
                dma_grant = dma_req && dma_lock && (burst_cnt < BURST_LIMIT);
                if (dma_grant) begin
                    burst_inc = 1'b1;
                    // Leave straight after the beat that uses up the budget.
                    if (burst_cnt == BURST_LAST) begin
                        state_d = S_YIELD;
                    end
                end else begin
                    state_d = S_YIELD;
                    // An exhausted budget idles this cycle; a DMA that simply
                    // let go hands the memory back to the CPU immediately.
                    cpu_grant = cpu_req && (burst_cnt < BURST_LIMIT);
                end
            end
            S_YIELD: begin
                cpu_grant = cpu_req;
                state_d   = S_CPU;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase

        // Nothing touches memory while reset is held.
        if (!rst) begin
            cpu_grant = 1'b0;
            dma_grant = 1'b0;
            burst_inc = 1'b0;
            state_d   = S_CPU;
        end
    end

    assign mem_a     = dma_grant ? dma_addr  : cpu_addr;
    assign mem_wd    = dma_grant ? dma_wdata : cpu_wdata;
    assign mem_we    = (cpu_grant && cpu_we) || (dma_grant && dma_we);
    assign cpu_rdata = mem_rd;
    assign cpu_stall = rst && cpu_req && !cpu_grant;
    assign dma_gnt   = dma_grant;

    always_comb begin
        dma_rvalid_d = dma_grant && !dma_we;
        dma_rdata_d  = dma_rvalid_d ? mem_rd : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_CPU;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule
